// File: rtl/aes_io_pkg.sv
// Shared types and constants for the word-serial AES128 front/back end.
package aes_io_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_OUT   = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam int KEY_WORDS              = 4;
  localparam int DATA_WORDS             = 4;
  localparam int FRAME_WORDS            = KEY_WORDS + DATA_WORDS;
  localparam int WORD_IDX_W             = 2;
  localparam int FRAME_CNT_W            = 3;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  // Word 0 is the most significant 32 bits: lsb = 96 - 32*idx.
  function automatic logic [6:0] word_lsb(input logic [WORD_IDX_W-1:0] idx);
    return {~idx, 5'd0};
  endfunction

endpackage

// File: rtl/aes_word_serializer.sv
// Captures a 128-bit ciphertext and streams it out as four 32-bit words, MSW first.
module aes_word_serializer
  import aes_io_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         capture,
  input  logic [127:0] capture_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         last_xfer
);

  logic [127:0]          buf_q;
  logic [WORD_IDX_W-1:0] idx_q;
  logic                  valid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (capture) begin
      buf_q   <= capture_data;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && m_ready) begin
      idx_q <= idx_q + 2'd1;
      if (idx_q == 2'd3) valid_q <= 1'b0;
    end
  end

  // Word is held until accepted: transfer = m_valid & m_ready.
  assign m_valid   = valid_q;
  assign m_data    = buf_q[word_lsb(idx_q) +: 32];
  assign last_xfer = valid_q && m_ready && (idx_q == 2'd3);

endmodule

// File: rtl/aes_stream_io.sv
// Word-serial key/plaintext loader, AES core sequencer and ciphertext streamer.
// Optional AES_KEY_REUSE_EN: s_newkey=0 on the first word selects a 4-word data-only frame.
module aes_stream_io
  import aes_io_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
`ifdef AES_KEY_REUSE_EN
  input  logic         s_newkey,
`endif
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         aes_ce,
  output logic [127:0] aes_key,
  output logic [127:0] aes_data_in,
  input  logic [127:0] aes_data_out,
  input  logic         aes_done,
  output logic         busy,
  output logic         error,
  output state_t       dbg_state
);

  state_t                 state;
  logic [FRAME_CNT_W-1:0] word_cnt;
  logic [7:0]             cyc_cnt;
  logic [127:0]           key_q;
  logic [127:0]           data_q;
  logic                   error_q;
  logic                   capture;
  logic                   last_xfer;
  logic [6:0]             lsb;

  assign lsb = word_lsb(word_cnt[WORD_IDX_W-1:0]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_LOAD;
      word_cnt <= '0;
      cyc_cnt  <= '0;
      key_q    <= '0;
      data_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (s_valid) begin
`ifdef AES_KEY_REUSE_EN
            // Data-only frame: jump the counter straight into the data half.
            if (word_cnt == '0 && !s_newkey) begin
              data_q[127:96] <= s_data;
              word_cnt       <= 3'd5;
            end else
`endif
            begin
              if (!word_cnt[2]) key_q[lsb +: 32]  <= s_data;
              else              data_q[lsb +: 32] <= s_data;
              if (word_cnt == 3'(FRAME_WORDS - 1)) begin
                state    <= ST_RUN;
                word_cnt <= '0;
                cyc_cnt  <= '0;
              end else begin
                word_cnt <= word_cnt + 3'd1;
              end
            end
          end
        end
        ST_RUN: begin
          if (aes_done) begin
            state <= ST_OUT;
          end else if (cyc_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            state   <= ST_ERROR;
            error_q <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
        ST_OUT: begin
          if (last_xfer) state <= ST_LOAD;
        end
        default: ;
      endcase
    end
  end

  assign s_ready     = (state == ST_LOAD);
  assign aes_ce      = (state == ST_RUN);
  assign capture     = aes_ce && aes_done;
  assign busy        = !(state == ST_LOAD && word_cnt == '0);
  assign error       = error_q;
  assign aes_key     = key_q;
  assign aes_data_in = data_q;
  assign dbg_state   = state;

  aes_word_serializer u_ser (
    .clock        (clock),
    .reset_n      (reset_n),
    .capture      (capture),
    .capture_data (aes_data_out),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .last_xfer    (last_xfer)
  );

endmodule

// File: tb/tb_aes_stream_io.sv
// Bench for aes_stream_io with a behavioural AES core stand-in and an output scoreboard.
module tb_aes_stream_io;
  import aes_io_pkg::*;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         s_newkey = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [31:0]  m_data;
  logic         aes_ce;
  logic [127:0] aes_key;
  logic [127:0] aes_data_in;
  logic [127:0] aes_data_out = '0;
  logic         aes_done = 1'b0;
  logic         busy;
  logic         error;
  state_t       dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  exp_w;
  logic [127:0] model_key = '0;
  logic [127:0] model_pt = '0;
  logic         ce_before;
  int core_lat = 10;
  bit core_hang = 1'b0;
  int core_cnt = 0;

  always #5 clock = ~clock;

  aes_stream_io #(.TIMEOUT_CYCLES(64)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
`ifdef AES_KEY_REUSE_EN
    .s_newkey     (s_newkey),
`endif
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .aes_ce       (aes_ce),
    .aes_key      (aes_key),
    .aes_data_in  (aes_data_in),
    .aes_data_out (aes_data_out),
    .aes_done     (aes_done),
    .busy         (busy),
    .error        (error),
    .dbg_state    (dbg_state)
  );

  // Core stand-in: the FIPS-197 C.1 vector is exact, anything else uses a keyed mixing function.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return (k ^ {p[63:0], p[127:64]}) + 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  always @(posedge clock) begin
    if (!aes_ce) begin
      core_cnt <= 0;
      aes_done <= 1'b0;
    end else if (!aes_done) begin
      if (!core_hang && core_cnt >= core_lat - 1) begin
        aes_done     <= 1'b1;
        aes_data_out <= core_fn(aes_key, aes_data_in);
      end else begin
        core_cnt     <= core_cnt + 1;
        aes_data_out <= {4{$urandom()}};
      end
    end
  end

  // Output scoreboard: every accepted word must be the next expected one.
  always @(negedge clock) begin
    if (reset_n && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_extra got=%h expected=none", m_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (m_data !== exp_w) begin
          failures++;
          $display("FAIL out_word got=%h exp=%h", m_data, exp_w);
        end
      end
    end
  end

  // Key and plaintext presented to the core must not move while it runs.
  always @(negedge clock) begin
    if (reset_n && aes_ce) begin
      checks++;
      if (aes_key !== model_key || aes_data_in !== model_pt) begin
        failures++;
        $display("FAIL run_inputs key=%h data=%h exp_key=%h exp_data=%h",
                 aes_key, aes_data_in, model_key, model_pt);
      end
    end
  end

  task automatic expect_block(input logic [127:0] ct);
    for (int i = 0; i < 4; i++) exp_q.push_back(ct[127-32*i -: 32]);
  endtask

  task automatic send_word(input logic [31:0] w, input logic nk, input int gap);
    bit ok = 1'b0;
    s_valid  = 1'b1;
    s_data   = w;
    s_newkey = nk;
    for (int t = 0; t < 50; t++) begin
      @(negedge clock);
      if (s_ready) begin
        ok = 1'b1;
        ce_before = aes_ce;
        break;
      end
      @(posedge clock); #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL s_ready_timeout got=0 exp=1");
    end
    @(posedge clock); #1;
    s_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clock); #1;
    end
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle per word, 2 random idles.
  task automatic send_frame(input logic [127:0] key, input logic [127:0] pt,
                            input logic newkey, input int gap_mode);
    logic [31:0] words[8];
    int n;
    int gap;
`ifndef AES_KEY_REUSE_EN
    newkey = 1'b1;
`endif
    n = 0;
    if (newkey) begin
      for (int i = 0; i < 4; i++) words[n++] = key[127-32*i -: 32];
      model_key = key;
    end
    for (int i = 0; i < 4; i++) words[n++] = pt[127-32*i -: 32];
    model_pt = pt;
    for (int i = 0; i < n; i++) begin
      gap = (i == n - 1) ? 0 : (gap_mode == 1) ? 1 :
            (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      send_word(words[i], (i == 0) ? newkey : 1'b0, gap);
      if (i == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_after_first got=%b exp=1", busy);
        end
      end
    end
    checks++;
    if (ce_before !== 1'b0 || aes_ce !== 1'b1) begin
      failures++;
      $display("FAIL ce_rise before=%b after=%b exp=0/1", ce_before, aes_ce);
    end
    checks++;
    if (aes_key !== model_key || aes_data_in !== model_pt) begin
      failures++;
      $display("FAIL loaded key=%h data=%h exp_key=%h exp_data=%h",
               aes_key, aes_data_in, model_key, model_pt);
    end
  endtask

  task automatic drain(input bit random_ready);
    bit done = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(posedge clock); #1;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      m_ready = random_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    m_ready = 1'b0;
    checks++;
    if (!done || s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain done=%b left=%0d s_ready=%b busy=%b m_valid=%b exp=1/0/1/0/0",
               done, exp_q.size(), s_ready, busy, m_valid);
    end
  endtask

  task automatic apply_reset();
    @(posedge clock); #2;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_key = '0;
    model_pt  = '0;
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || aes_ce !== 1'b0 || busy !== 1'b0 ||
        error !== 1'b0 || aes_key !== '0 || aes_data_in !== '0 || dbg_state !== ST_LOAD) begin
      failures++;
      $display("FAIL %s s_ready=%b m_valid=%b ce=%b busy=%b err=%b key=%h din=%h st=%0d exp=1,0,0,0,0,0,0,0",
               tag, s_ready, m_valid, aes_ce, busy, error, aes_key, aes_data_in, dbg_state);
    end
  endtask

  task automatic test_reset();
    #2;
    check_reset_values("reset_values");
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) send_word($urandom(), 1'b1, 0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_partial got=%b exp=1", busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("reset_mid_frame");
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_fips();
    core_lat = 37;
    expect_block(FIPS_CT);
    send_frame(FIPS_KEY, FIPS_PT, 1'b1, 0);
    drain(1'b0);
  endtask

  task automatic test_toggle_load();
    core_lat = 12;
    expect_block(FIPS_CT);
    send_frame(FIPS_KEY, FIPS_PT, 1'b1, 1);
    drain(1'b1);
  endtask

  task automatic test_out_stall();
    core_lat = 5;
    expect_block(FIPS_CT);
    send_frame(FIPS_KEY, FIPS_PT, 1'b1, 0);
    m_ready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(posedge clock); #1;
      if (exp_q.size() == 3) break;
    end
    m_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'h6a7b0430) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d m_valid=%b m_data=%h exp=1/6a7b0430", c, m_valid, m_data);
      end
    end
    @(posedge clock); #1;
    drain(1'b0);
  endtask

  task automatic test_random();
    logic [127:0] k, p;
    for (int f = 0; f < 5; f++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      core_lat = $urandom_range(1, 40);
      expect_block(core_fn(k, p));
      send_frame(k, p, 1'b1, 2);
      drain(1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k, p;
    core_lat = 1;
    for (int f = 0; f < 3; f++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      expect_block(core_fn(k, p));
      send_frame(k, p, 1'b1, 0);
      drain(1'b0);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    core_hang = 1'b1;
    send_frame(FIPS_KEY, FIPS_PT, 1'b1, 0);
    for (int t = 0; t < 300; t++) begin
      @(negedge clock);
      if (error) break;
      if (aes_ce) n++;
    end
    checks++;
    if (n !== 64 || error !== 1'b1) begin
      failures++;
      $display("FAIL timeout_cycles got=%0d err=%b exp=64/1", n, error);
    end
    s_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++;
      if (aes_ce !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0 || error !== 1'b1 ||
          dbg_state !== ST_ERROR) begin
        failures++;
        $display("FAIL error_hold ce=%b s_ready=%b m_valid=%b err=%b st=%0d exp=0/0/0/1/3",
                 aes_ce, s_ready, m_valid, error, dbg_state);
      end
    end
    s_valid = 1'b0;
    core_hang = 1'b0;
    apply_reset();
    check_reset_values("reset_after_error");
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    core_lat = 60;
    send_frame(FIPS_KEY, FIPS_PT, 1'b1, 0);
    for (int t = 0; t < 100 && n < 20; t++) begin
      @(negedge clock);
      if (aes_ce) n++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("reset_mid_run");
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_key = '0;
    model_pt  = '0;
    exp_q.delete();
    core_lat = 9;
    expect_block(FIPS_CT);
    send_frame(FIPS_KEY, FIPS_PT, 1'b1, 0);
    drain(1'b0);
  endtask

`ifdef AES_KEY_REUSE_EN
  task automatic test_key_reuse();
    logic [127:0] p;
    core_lat = 20;
    expect_block(FIPS_CT);
    send_frame(FIPS_KEY, FIPS_PT, 1'b1, 0);
    drain(1'b0);
    expect_block(FIPS_CT);
    send_frame(128'h0, FIPS_PT, 1'b0, 1);
    drain(1'b1);
    p = {$urandom(), $urandom(), $urandom(), $urandom()};
    expect_block(core_fn(FIPS_KEY, p));
    send_frame(128'h0, p, 1'b0, 2);
    drain(1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_fips();
    test_toggle_load();
    test_out_stall();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid_run();
`ifdef AES_KEY_REUSE_EN
    test_key_reuse();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
